// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive framer: FSM states,
// default frame parameters and the bit positions of the registered status pulses.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } state_e;

    localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
    localparam int         MAX_LEN_DEFAULT = 16;
    localparam int         TIMEOUT_DEFAULT = 240;

    localparam int PULSE_W       = 5;
    localparam int P_FRAME_OK    = 0;
    localparam int P_ERR_CHK     = 1;
    localparam int P_ERR_LEN     = 2;
    localparam int P_ERR_TIMEOUT = 3;
    localparam int P_ERR_OVERRUN = 4;

    // Width of an index or counter covering 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: DEPTH x 8 register file, one synchronous write
// port and one asynchronous read port.
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int DEPTH  = MAX_LEN_DEFAULT,
    parameter int ADDR_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_q [DEPTH];

    // NOTE: the array has no reset; every location is written before DRAIN can read it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_framer.sv
// Frame controller behind the UART byte receiver: hunts SOF, collects a
// length-prefixed payload, checks its XOR sum and streams good payloads out.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         MAX_LEN = MAX_LEN_DEFAULT,
    parameter int         TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);

    localparam int         PTR_W     = idx_width(MAX_LEN);
    localparam int         LEN_W     = $clog2(MAX_LEN + 1);
    localparam int         GAP_W     = idx_width(TIMEOUT);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [7:0]           acc_q, acc_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;

    logic                 len_bad;
    logic                 wr_done;
    logic                 rd_done;
    logic                 timed;
    logic                 gap_expire;
    logic                 xfer;
    logic                 buf_wr_en;
    logic [7:0]           buf_rd_data;

    // The LEN byte is range-checked at full 8-bit width, before it is narrowed into len.
    assign len_bad    = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
    assign wr_done    = (LEN_W'(wr_ptr_q) == (len_q - LEN_W'(1)));
    assign rd_done    = (LEN_W'(rd_ptr_q) == (len_q - LEN_W'(1)));
    assign timed      = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
    assign gap_expire = timed && clk_en && !rx_valid && (gap_q == GAP_W'(TIMEOUT - 1));
    assign xfer       = (state_q == DRAIN) && out_ready;
    assign buf_wr_en  = (state_q == PAYLOAD) && rx_valid;

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (PTR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_q),
        .rd_data (buf_rd_data)
    );

    // NOTE: sequential state is assigned only with <=, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (rx_valid && (rx_data == SOF)) state_d = LEN;
            end
            LEN: begin
                if (gap_expire)    state_d = HUNT;
                else if (rx_valid) state_d = len_bad ? HUNT : PAYLOAD;
            end
            PAYLOAD: begin
                if (gap_expire)               state_d = HUNT;
                else if (rx_valid && wr_done) state_d = CHK;
            end
            CHK: begin
                if (gap_expire)    state_d = HUNT;
                else if (rx_valid) state_d = (rx_data == acc_q) ? DRAIN : HUNT;
            end
            DRAIN: begin
                if (xfer && rd_done) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        acc_d    = acc_q;
        pulse_d  = '0;

        // Gap counter only lives in the receiving states; any byte restarts it.
        if (!timed || rx_valid || gap_expire) begin
            gap_d = '0;
        end else if (clk_en) begin
            gap_d = gap_q + GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end

        if (gap_expire) begin
            pulse_d[P_ERR_TIMEOUT] = 1'b1;
        end

        case (state_q)
            LEN: begin
                if (rx_valid) begin
                    if (len_bad) begin
                        pulse_d[P_ERR_LEN] = 1'b1;
                    end else begin
                        len_d    = LEN_W'(rx_data);
                        acc_d    = rx_data;
                        wr_ptr_d = '0;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    acc_d    = acc_q ^ rx_data;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (rx_data == acc_q) begin
                        pulse_d[P_FRAME_OK] = 1'b1;
                        rd_ptr_d            = '0;
                    end else begin
                        pulse_d[P_ERR_CHK] = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (rx_valid) pulse_d[P_ERR_OVERRUN] = 1'b1;
                if (xfer)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            acc_q    <= '0;
            gap_q    <= '0;
            pulse_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            gap_q    <= gap_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        busy        = (state_q != HUNT);
        out_valid   = (state_q == DRAIN);
        out_last    = (state_q == DRAIN) && rd_done;
        // Buffer contents are undefined after reset, so the data bus is gated to zero outside DRAIN.
        out_data    = (state_q == DRAIN) ? buf_rd_data : 8'h00;
        frame_ok    = pulse_q[P_FRAME_OK];
        err_chk     = pulse_q[P_ERR_CHK];
        err_len     = pulse_q[P_ERR_LEN];
        err_timeout = pulse_q[P_ERR_TIMEOUT];
        err_overrun = pulse_q[P_ERR_OVERRUN];
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: per-feature tasks plus a scoreboard
// that pops expected payload bytes as the DUT transfers them.
module tb_uart_rx_framer;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       frame_ok;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    int cnt_ok       = 0;
    int cnt_chk      = 0;
    int cnt_len      = 0;
    int cnt_timeout  = 0;
    int cnt_overrun  = 0;
    int cnt_valid    = 0;

    exp_t       exp_q [$];
    logic [7:0] frame_q [$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    uart_rx_framer dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .frame_ok    (frame_ok),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Monitor: pulse counting, stall stability and scoreboard pops, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_ok)    cnt_ok++;
            if (err_chk)     cnt_chk++;
            if (err_len)     cnt_len++;
            if (err_timeout) cnt_timeout++;
            if (err_overrun) cnt_overrun++;
            if (out_valid)   cnt_valid++;
            if (prev_stall) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_extra: got data=%h last=%b, required no transfer", out_data, out_last);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        tests_failed++;
                        $display("FAIL scoreboard_data: got data=%h last=%b, required data=%h last=%b",
                                 out_data, out_last, e.data, e.last);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    // Drives a one-cycle byte strobe; entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Sends SOF, LEN, frame_q and the correct checksum; loads the scoreboard.
    task automatic send_frame();
        logic [7:0] chk;
        int         n;
        n   = frame_q.size();
        chk = 8'(n);
        foreach (frame_q[i]) chk ^= frame_q[i];
        for (int i = 0; i < n; i++) exp_q.push_back('{data: frame_q[i], last: (i == n - 1)});
        send_byte(SOF_DEFAULT);
        send_byte(8'(n));
        foreach (frame_q[i]) send_byte(frame_q[i]);
        send_byte(chk);
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        tests_run++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_idle: got busy=%b pending=%0d, required busy=0 pending=0", name, busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        clk_en    = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b1;
        #3;
        tests_run++;
        if ({out_valid, out_data, out_last, busy} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_stream: got valid=%b data=%h last=%b busy=%b, required all 0",
                     out_valid, out_data, out_last, busy);
        end
        tests_run++;
        if ({frame_ok, err_chk, err_len, err_timeout, err_overrun} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b, required 00000",
                     {frame_ok, err_chk, err_len, err_timeout, err_overrun});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_bytes [3];
        int         base_ok;
        exp_bytes = '{8'h11, 8'h22, 8'h33};
        base_ok   = cnt_ok;
        out_ready = 1'b1;
        frame_q   = '{8'h11, 8'h22, 8'h33};
        send_frame();
        tests_run++;
        if (frame_ok !== 1'b1 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL good_first_cycle: got frame_ok=%b valid=%b, required 1 1", frame_ok, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_bytes[k] || out_last !== (k == 2)) begin
                tests_failed++;
                $display("FAIL good_beat%0d: got valid=%b data=%h last=%b, required 1 %h %b",
                         k, out_valid, out_data, out_last, exp_bytes[k], (k == 2));
            end
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || cnt_ok - base_ok != 1) begin
            tests_failed++;
            $display("FAIL good_end: got busy=%b valid=%b ok_pulses=%0d, required 0 0 1",
                     busy, out_valid, cnt_ok - base_ok);
        end
    endtask

    task automatic test_bad_checksum();
        int base_valid, base_chk, base_ok;
        base_valid = cnt_valid;
        base_chk   = cnt_chk;
        base_ok    = cnt_ok;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h00);
        tests_run++;
        if (err_chk !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL badchk_pulse: got err_chk=%b valid=%b busy=%b, required 1 0 0", err_chk, out_valid, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (cnt_valid != base_valid || cnt_chk - base_chk != 1 || cnt_ok != base_ok) begin
            tests_failed++;
            $display("FAIL badchk_counts: got valid_cycles=%0d chk=%0d ok=%0d, required 0 1 0",
                     cnt_valid - base_valid, cnt_chk - base_chk, cnt_ok - base_ok);
        end
        frame_q = '{8'hC3, 8'h3C};
        send_frame();
        wait_idle("badchk_recover");
        tests_run++;
        if (cnt_ok - base_ok != 1) begin
            tests_failed++;
            $display("FAIL badchk_recover_ok: got ok=%0d, required 1", cnt_ok - base_ok);
        end
    endtask

    task automatic test_len_errors();
        int base_len, base_all;
        base_len = cnt_len;
        base_all = cnt_ok + cnt_chk + cnt_timeout + cnt_overrun;
        send_byte(8'hA5);
        send_byte(8'h00);
        tests_run++;
        if (err_len !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL len_zero: got err_len=%b busy=%b, required 1 0", err_len, busy);
        end
        send_byte(8'hA5);
        send_byte(8'h11);
        tests_run++;
        if (err_len !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL len_over: got err_len=%b busy=%b, required 1 0", err_len, busy);
        end
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (cnt_len - base_len != 2 || cnt_ok + cnt_chk + cnt_timeout + cnt_overrun != base_all || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL len_hunt_quiet: got len_pulses=%0d other=%0d busy=%b, required 2 0 0",
                     cnt_len - base_len, cnt_ok + cnt_chk + cnt_timeout + cnt_overrun - base_all, busy);
        end
        frame_q = {};
        for (int i = 0; i < 16; i++) frame_q.push_back(8'(i * 17 + 1));
        send_frame();
        wait_idle("len_max");
        tests_run++;
        if (cnt_len - base_len != 2 || cnt_ok + cnt_chk + cnt_timeout + cnt_overrun != base_all + 1) begin
            tests_failed++;
            $display("FAIL len_max_ok: got len_pulses=%0d other=%0d, required 2 1",
                     cnt_len - base_len, cnt_ok + cnt_chk + cnt_timeout + cnt_overrun - base_all);
        end
    endtask

    task automatic test_timeout();
        int base_to, base_ok;
        base_to = cnt_timeout;
        base_ok = cnt_ok;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        for (int i = 1; i <= 240; i++) begin
            clk_en = 1'b1;
            @(posedge clk);
            #1;
            clk_en = 1'b0;
            if (i == 239) begin
                tests_run++;
                if (cnt_timeout != base_to || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL timeout_early: got pulses=%0d busy=%b at tick 239, required 0 1",
                             cnt_timeout - base_to, busy);
                end
            end
            if (i == 240) begin
                tests_run++;
                if (err_timeout !== 1'b1 || busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL timeout_fire: got err_timeout=%b busy=%b at tick 240, required 1 0",
                             err_timeout, busy);
                end
            end
            @(posedge clk);
            #1;
        end
        base_to = cnt_timeout;
        exp_q.push_back('{data: 8'hAA, last: 1'b0});
        exp_q.push_back('{data: 8'h55, last: 1'b1});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        for (int i = 1; i <= 239; i++) begin
            clk_en = 1'b1;
            @(posedge clk);
            #1;
            clk_en = 1'b0;
            @(posedge clk);
            #1;
        end
        clk_en = 1'b1;
        send_byte(8'h55);
        clk_en = 1'b0;
        tests_run++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_race: got err_timeout=%b busy=%b, required 0 1", err_timeout, busy);
        end
        send_byte(8'hFD);
        wait_idle("timeout_race");
        tests_run++;
        if (cnt_timeout != base_to || cnt_ok - base_ok != 1) begin
            tests_failed++;
            $display("FAIL timeout_race_counts: got timeouts=%0d ok=%0d, required 0 1",
                     cnt_timeout - base_to, cnt_ok - base_ok);
        end
    endtask

    task automatic test_stall_overrun();
        int base_ov, base_ok, cyc;
        base_ov   = cnt_overrun;
        base_ok   = cnt_ok;
        out_ready = 1'b0;
        frame_q   = '{8'h0F, 8'hF0, 8'h81, 8'h7E};
        send_frame();
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            out_ready = cyc[0];
            rx_valid  = (cyc == 1) || (cyc == 3);
            rx_data   = (cyc == 1) ? SOF_DEFAULT : 8'h00;
            @(posedge clk);
            #1;
            cyc++;
        end
        rx_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stall_drain: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
        end
        tests_run++;
        if (cnt_overrun - base_ov != 2 || cnt_ok - base_ok != 1) begin
            tests_failed++;
            $display("FAIL stall_overrun: got overruns=%0d ok=%0d, required 2 1",
                     cnt_overrun - base_ov, cnt_ok - base_ok);
        end
    endtask

    task automatic test_reset_mid_payload();
        int base_all;
        base_all = cnt_ok + cnt_chk + cnt_len + cnt_timeout + cnt_overrun;
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, out_data, out_last, busy, frame_ok, err_chk, err_len, err_timeout, err_overrun} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got valid=%b data=%h last=%b busy=%b, required all 0",
                     out_valid, out_data, out_last, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        frame_q = '{8'h5A, 8'hA5, 8'h00};
        send_frame();
        wait_idle("midreset");
        tests_run++;
        if (cnt_ok + cnt_chk + cnt_len + cnt_timeout + cnt_overrun - base_all != 1 || cnt_ok == 0) begin
            tests_failed++;
            $display("FAIL midreset_counts: got pulses=%0d, required 1 (frame_ok only)",
                     cnt_ok + cnt_chk + cnt_len + cnt_timeout + cnt_overrun - base_all);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_len_errors();
        test_timeout();
        test_stall_overrun();
        test_reset_mid_payload();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_leftover: got %0d pending bytes, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Frame controller downstream of the UART byte receiver. It hunts for a start-of-frame byte, collects a length-prefixed payload and verifies an XOR checksum. A good frame's payload is then released to the consumer over a valid/ready stream. It sequences the receiver's unbufferable byte strobes into checked packets and flags framing, length, timeout and overrun errors.

## Interface
- SOF, 8'hA5: start-of-frame byte value.
- MAX_LEN, 16: maximum payload bytes (≥1).
- TIMEOUT, 240: inter-byte gap limit in clk_en ticks (10 bit times at 24x oversampling).

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- clk_en  in  1  oversample tick shared with receiver; times the timeout only.
- rx_valid  in  1  one-cycle byte strobe from receiver.
- rx_data  in  8  received byte, valid with rx_valid.
- out_valid  out  1  payload byte available.
- out_data  out  8  payload byte.
- out_last  out  1  final payload byte of frame.
- out_ready  in  1  consumer accepts byte.
- frame_ok  out  1  pulse: frame passed checksum.
- err_chk  out  1  pulse: checksum mismatch.
- err_len  out  1  pulse: LEN byte 0 or >MAX_LEN.
- err_timeout  out  1  pulse: inter-byte gap exceeded.
- err_overrun  out  1  pulse: byte arrived during DRAIN and was dropped.
- busy  out  1  state ≠ HUNT.

## Operation
- Frame format: SOF, LEN, LEN payload bytes, CHK. CHK = XOR of LEN and all payload bytes.
- HUNT: bytes other than SOF are ignored silently. SOF → LEN state.
- LEN: a byte of 0 or >MAX_LEN → err_len, go to HUNT. Otherwise store len, set acc=LEN, wr_ptr=0, go to PAYLOAD.
- PAYLOAD: each byte is written to buf[wr_ptr], acc ^= byte, wr_ptr++. After len bytes → CHK.
- CHK: byte == acc → frame_ok, rd_ptr=0, go to DRAIN. Otherwise → err_chk, go to HUNT; no out_valid.
- DRAIN: out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1).
  - Each out_valid&&out_ready advances rd_ptr.
  - A transfer with out_last → HUNT.
  - Any rx_valid in DRAIN: byte dropped, err_overrun. A SOF is also dropped.
- Timeout: gap counter runs only in LEN/PAYLOAD/CHK.
  - Counter clears on every rx_valid and on entry to LEN.
  - Counter increments on clk_en.
  - clk_en with counter==TIMEOUT-1 and no rx_valid → err_timeout, go to HUNT.
  - rx_valid in the same cycle as that tick wins: the byte is processed and the counter is cleared.
- Widths: wr_ptr/rd_ptr $clog2(MAX_LEN); len $clog2(MAX_LEN+1), compared against 8-bit LEN before truncation; gap counter $clog2(TIMEOUT).

## Timing
- Reset: state HUNT. All outputs 0: out_data=0, out_valid, out_last, busy, and all pulses. Pointers, len, acc and counter are 0. Buffer contents are don't-care. Reset mid-frame or mid-DRAIN abandons the frame with no error pulse.
- State updates on the clk edge where rx_valid=1. Pulses are registered: each is high exactly one cycle, the cycle after the causing edge.
- frame_ok and the first out_valid rise in the same cycle: the cycle after the CHK strobe.
- Latency: with out_ready=1, payload byte k is transferred k cycles after out_valid rises (k=0..len-1). busy falls the cycle after the last transfer.
- out_data, out_last and out_valid hold stable while out_valid && !out_ready.
- out_valid is registered state, never combinational on out_ready.

## Structure
- Package uart_pkg: state enum (HUNT, LEN, PAYLOAD, CHK, DRAIN), SOF default constant, error-pulse index constants.
- Sub-module uart_frame_buf: MAX_LEN x 8 register file with one synchronous write port and one asynchronous read port. Pointers and FSM stay in uart_rx_framer.

## Test plan
- Good frame A5 03 11 22 33 03, out_ready=1 → frame_ok one pulse; out_data 11,22,33 on consecutive cycles; out_last only with 33; busy then 0.
- Bad checksum A5 02 AA 55 00 (expected FD) → err_chk pulse, out_valid never high. A following good frame is accepted.
- LEN 00, then LEN 11 (hex, =17) → err_len each time. Non-SOF bytes 00 FF 5A before SOF are ignored with no pulses.
- A5 02 AA then silence → err_timeout after exactly 240 clk_en ticks from AA. Repeat with a byte landing on tick 240 → byte accepted, no timeout.
- Good 4-byte frame, out_ready toggling 1/0 → data held stable while stalled, order preserved. Two bytes injected during DRAIN → two err_overrun pulses, payload unaffected.
- Assert rst mid-PAYLOAD → all outputs 0 immediately, state HUNT. The next full good frame completes normally.
